// File: rtl/ripple_carry_adder.sv
// N-bit ripple-carry adder: a structural chain of full-adder cells
// feeding a single output register stage.
module ripple_carry_adder #(
  parameter int N = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] Inp1,
  input  logic [N-1:0] Inp2,
  input  logic         Cin,
  output logic [N-1:0] Result,
  output logic         Cout
);

  logic [N:0]   w_carry;
  logic [N-1:0] w_sum;
  logic [N-1:0] r_result;
  logic         r_cout;

  assign w_carry[0] = Cin;

  // One full-adder cell per bit; the carry ripples through every cell.
  for (genvar gi = 0; gi < N; gi++) begin : g_cell
    logic w_prop;
    assign w_prop          = Inp1[gi] ^ Inp2[gi];
    assign w_sum[gi]       = w_prop ^ w_carry[gi];
    assign w_carry[gi + 1] = (Inp1[gi] & Inp2[gi]) | (w_carry[gi] & w_prop);
  end

  // Output register; asynchronous reset clears the sum and carry at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_result <= '0;
      r_cout   <= 1'b0;
    end else begin
      r_result <= w_sum;
      r_cout   <= w_carry[N];
    end
  end

  assign Result = r_result;
  assign Cout   = r_cout;

endmodule

// File: tb/tb_ripple_carry_adder.sv
// Self-checking bench for ripple_carry_adder at N=10 and N=1.
module tb_ripple_carry_adder;

  logic       clk;
  logic       rst;
  logic [9:0] a10, b10, res10;
  logic       cin10, cout10;
  logic [0:0] a1, b1, res1;
  logic       cin1, cout1;

  int n_vec;
  int n_err;

  typedef struct {
    string      name;
    logic [9:0] a;
    logic [9:0] b;
    logic       cin;
    logic [9:0] res;
    logic       cout;
  } vec10_t;

  typedef struct {
    logic a;
    logic b;
    logic cin;
    logic res;
    logic cout;
  } vec1_t;

  vec10_t tbl10[10];
  vec1_t  tbl1[8];

  ripple_carry_adder #(.N(10)) u_dut10 (
    .clk    (clk),
    .rst    (rst),
    .Inp1   (a10),
    .Inp2   (b10),
    .Cin    (cin10),
    .Result (res10),
    .Cout   (cout10)
  );

  ripple_carry_adder #(.N(1)) u_dut1 (
    .clk    (clk),
    .rst    (rst),
    .Inp1   (a1),
    .Inp2   (b1),
    .Cin    (cin1),
    .Result (res1),
    .Cout   (cout1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [10:0] act, input logic [10:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got {cout,res}=0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [10:0] exp10;
    logic [1:0]  exp1;
    n_vec = 0;
    n_err = 0;

    tbl10[0] = '{"tp1_650",       10'd250,  10'd400,  1'b0, 10'd650,  1'b0};
    tbl10[1] = '{"tp2_wrap",      10'd750,  10'd300,  1'b0, 10'd26,   1'b1};
    tbl10[2] = '{"tp3_cin",       10'd250,  10'd400,  1'b1, 10'd651,  1'b0};
    tbl10[3] = '{"full_ripple",   10'd1023, 10'd0,    1'b1, 10'd0,    1'b1};
    tbl10[4] = '{"max_max_1",     10'd1023, 10'd1023, 1'b1, 10'd1023, 1'b1};
    tbl10[5] = '{"zero",          10'd0,    10'd0,    1'b0, 10'd0,    1'b0};
    tbl10[6] = '{"msb_carry",     10'd512,  10'd512,  1'b0, 10'd0,    1'b1};
    tbl10[7] = '{"max_max_0",     10'd1023, 10'd1023, 1'b0, 10'd1022, 1'b1};
    tbl10[8] = '{"alt_nocarry",   10'd341,  10'd682,  1'b0, 10'd1023, 1'b0};
    tbl10[9] = '{"alt_ripple",    10'd341,  10'd682,  1'b1, 10'd0,    1'b1};

    tbl1[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl1[1] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl1[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl1[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl1[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl1[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl1[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl1[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

    // Reset state before any clock edge.
    rst   = 1'b1;
    a10   = 10'd250;
    b10   = 10'd400;
    cin10 = 1'b0;
    a1    = 1'b1;
    b1    = 1'b1;
    cin1  = 1'b1;
    #2;
    chk("reset10", {cout10, res10}, 11'd0);
    chk("reset1", {9'd0, cout1, res1}, 11'd0);
    step();
    chk("reset10_held", {cout10, res10}, 11'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed N=10 table.
    for (int unsigned i = 0; i < 10; i++) begin
      @(negedge clk);
      a10   = tbl10[i].a;
      b10   = tbl10[i].b;
      cin10 = tbl10[i].cin;
      step();
      chk(tbl10[i].name, {cout10, res10}, {tbl10[i].cout, tbl10[i].res});
    end

    // Exhaustive N=1 table.
    for (int unsigned i = 0; i < 8; i++) begin
      @(negedge clk);
      a1   = tbl1[i].a;
      b1   = tbl1[i].b;
      cin1 = tbl1[i].cin;
      step();
      chk($sformatf("n1_%0d", i), {9'd0, cout1, res1}, {9'd0, tbl1[i].cout, tbl1[i].res});
    end

    // Asynchronous reset between edges while Result=650.
    @(negedge clk);
    a10   = 10'd250;
    b10   = 10'd400;
    cin10 = 1'b0;
    step();
    chk("pre_rst_650", {cout10, res10}, {1'b0, 10'd650});
    #2;
    rst = 1'b1;
    #1;
    chk("async_clear", {cout10, res10}, 11'd0);
    step();
    chk("rst_hold1", {cout10, res10}, 11'd0);
    step();
    chk("rst_hold2", {cout10, res10}, 11'd0);
    @(negedge clk);
    rst   = 1'b0;
    a10   = 10'd100;
    b10   = 10'd200;
    cin10 = 1'b1;
    #1;
    chk("rst_release_pre_edge", {cout10, res10}, 11'd0);
    step();
    chk("first_after_release", {cout10, res10}, {1'b0, 10'd301});

    // Random sweep against the behavioural sum, both widths in parallel.
    for (int unsigned i = 0; i < 1000; i++) begin
      @(negedge clk);
      a10   = 10'($urandom);
      b10   = 10'($urandom);
      cin10 = 1'($urandom);
      a1    = 1'($urandom);
      b1    = 1'($urandom);
      cin1  = 1'($urandom);
      exp10 = {1'b0, a10} + {1'b0, b10} + {10'd0, cin10};
      exp1  = {1'b0, a1} + {1'b0, b1} + {1'b0, cin1};
      step();
      chk("rand10", {cout10, res10}, exp10);
      chk("rand1", {9'd0, cout1, res1}, {9'd0, exp1});
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ripple_carry_adder.md
Name: ripple_carry_adder

Overview:
Parameterised N-bit binary adder built as a ripple chain of N one-bit full-adder cells, with a registered output stage. Computes Result = Inp1 + Inp2 + Cin, with the carry out of the top bit on Cout. Serves as the baseline (slowest, smallest) adder in the fast-adder family, used as the golden comparison for the carry-lookahead and carry-select variants.

Parameters:
N, 10, operand and result width in bits; legal range N >= 1.

Ports:
clk  input  1  rising-edge clock for the output register.
rst  input  1  asynchronous, active-high reset.
Inp1  input  N  first operand, unsigned.
Inp2  input  N  second operand, unsigned.
Cin  input  1  carry into bit 0.
Result  output  N  registered sum bits [N-1:0].
Cout  output  1  registered carry out of bit N-1.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high. Clock port is clk, reset port is rst.
- Datapath: N full-adder cells, generated structurally. Cell i computes s[i] = a[i] ^ b[i] ^ c[i] and c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i])). c[0] = Cin; Cout_next = c[N]. There are no lookahead or skip paths, so the carry must ripple through every cell.
- Arithmetic: unsigned modulo 2^N. {Cout, Result} equals Inp1 + Inp2 + Cin exactly as an (N+1)-bit value. No signed overflow flag is produced.
- Register stage: on each rising clk edge with rst low, Result <= s[N-1:0] and Cout <= c[N].
- Latency: 1 cycle. Inputs that are stable before a rising edge appear on the outputs after that edge.
- Throughput: one addition per cycle. There is no handshake; the inputs are sampled on every edge.
- Reset: rst high forces Result = 0 and Cout = 0 immediately, independent of clk. The outputs are held at 0 while rst is high. The first valid sum appears on the first rising edge after rst is released.
- Reset mid-operation: the in-flight sum is discarded and the outputs clear at once. There is no recovery state.
- Boundaries:
  - all-ones + all-ones + 1 gives Result = all-ones, Cout = 1.
  - 0 + 0 + 0 gives 0, 0.
  - all-ones + 0 + 1 gives Result = 0, Cout = 1. This case exercises the full-length carry ripple.
- The combinational path from the input pins to the register D inputs is the critical path and scales as O(N). The block has no timing requirement beyond meeting clk at the configured N.
- X handling: no special treatment. X on any input propagates into the register.

Test Plan:
1. N=10, rst pulse, then Inp1=250, Inp2=400, Cin=0 held over an edge -> Result=650, Cout=0.
2. N=10, Inp1=750, Inp2=300, Cin=0 -> Result=26, Cout=1 (1050 wraps modulo 1024).
3. N=10, Inp1=250, Inp2=400, Cin=1 -> Result=651, Cout=0.
4. N=10, Inp1=1023, Inp2=0, Cin=1 -> Result=0, Cout=1 (full-length ripple). Also 1023+1023+1 -> Result=1023, Cout=1.
5. Assert rst asynchronously between edges while Result=650 -> Result=0 and Cout=0 immediately, held until release. On the first edge after release the outputs show the current inputs' sum.
6. Randomised sweep, 1000 vectors at N=10 and at N=1, compared against the behavioural model {Cout, Result} = Inp1 + Inp2 + Cin one cycle later -> zero mismatches.
